// File: rtl/my_downconverter.sv
// my_downconverter: transmit-side AXI4-Stream width converter.
// Serialises 256-bit packet beats into 64-bit beats for the 10G MAC side.
// Trailing all-zero lanes on a packet's final beat are dropped. TUSER is
// latched on the first beat of each packet and held for the whole packet.
// The byte length in TUSER[15:0] is checked against the bytes emitted.
//
// Ports:
//   axi_aclk, axi_reset           clock, synchronous active-high reset
//   s_axis_t{data,strb,user,valid,last} / s_axis_tready   256-bit slave
//   m_axis_t{data,strb,user,valid,last} / m_axis_tready   64-bit master
//   len_err        one-cycle pulse after a packet with a length mismatch
//   len_err_count  saturating count of mismatched packets
module my_downconverter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            len_err,
  output logic [15:0]                     len_err_count
);

  localparam int LANE_W = C_M_AXIS_DATA_WIDTH;
  localparam int LANE_B = C_M_AXIS_DATA_WIDTH / 8;
  localparam int LANES  = C_S_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH;

  typedef enum logic {SOP, IN_PKT} trk_state_t;

  // Holding register
  logic [C_S_AXIS_DATA_WIDTH-1:0]   hold_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] hold_strb;
  logic                             hold_last;
  logic                             hold_valid;
  logic [1:0]                       idx;
  logic [1:0]                       final_lane;

  logic [C_M_AXIS_TUSER_WIDTH-1:0]  tuser_reg;
  logic [15:0]                      byte_cnt;
  logic [15:0]                      out_pop;
  logic [1:0]                       in_last_lane;
  logic                             at_final;
  logic                             in_fire;
  logic                             out_fire;
  logic                             latch_tuser;

  trk_state_t state, state_nxt;

  assign at_final = (idx == final_lane);
  assign in_fire  = s_axis_tvalid && s_axis_tready;
  assign out_fire = hold_valid && m_axis_tready;

  // A new beat is accepted only when the held one is gone or is leaving now,
  // so the output never stalls between consecutive input beats.
  assign s_axis_tready = !axi_reset && (!hold_valid || (m_axis_tready && at_final));

  // Outputs are driven straight from registers; idle outputs read as zero.
  assign m_axis_tvalid = hold_valid;
  assign m_axis_tdata  = hold_valid ? hold_data[{idx, 6'd0} +: LANE_W] : '0;
  assign m_axis_tstrb  = hold_valid ? hold_strb[{idx, 3'd0} +: LANE_B] : '0;
  assign m_axis_tlast  = hold_valid && hold_last && at_final;
  assign m_axis_tuser  = tuser_reg;

  assign out_pop = 16'($countones(m_axis_tstrb));

  // Highest lane of the incoming beat that carries at least one byte.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_last_lane = 2'd0;
    for (int k = 0; k < LANES; k++) begin
      if (|s_axis_tstrb[k*LANE_B +: LANE_B]) in_last_lane = 2'(k);
    end
  end

  // NOTE: the wide data/strobe store carries no reset; hold_valid gates it,
  // so resetting 288 flops would buy nothing.
  always_ff @(posedge axi_aclk) begin
    if (in_fire) begin
      hold_data <= s_axis_tdata;
      hold_strb <= s_axis_tstrb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      idx        <= 2'd0;
      final_lane <= 2'd0;
    end else if (in_fire) begin
      hold_valid <= 1'b1;
      hold_last  <= s_axis_tlast;
      idx        <= 2'd0;
      final_lane <= s_axis_tlast ? in_last_lane : 2'(LANES - 1);
    end else if (out_fire) begin
      if (at_final) hold_valid <= 1'b0;
      else          idx        <= idx + 2'd1;
    end
  end

  // Length check: bytes are counted as they leave, compared on tlast.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      byte_cnt      <= 16'd0;
      len_err       <= 1'b0;
      len_err_count <= 16'd0;
    end else begin
      len_err <= 1'b0;
      if (out_fire) begin
        if (m_axis_tlast) begin
          byte_cnt <= 16'd0;
          if ((byte_cnt + out_pop) != tuser_reg[15:0]) begin
            len_err <= 1'b1;
            if (len_err_count != 16'hFFFF) len_err_count <= len_err_count + 16'd1;
          end
        end else begin
          byte_cnt <= byte_cnt + out_pop;
        end
      end
    end
  end

  // Packet tracker: state register
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state <= SOP;
    else           state <= state_nxt;
  end

  // Packet tracker: next state
  always_comb begin
    state_nxt = state;
    if (in_fire) state_nxt = s_axis_tlast ? SOP : IN_PKT;
  end

  // Packet tracker: outputs
  always_comb begin
    latch_tuser = 1'b0;
    if (state == SOP) latch_tuser = in_fire;
  end

  // The register updates only at a packet start, which is never earlier than
  // the cycle the previous packet's last lane leaves.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset)        tuser_reg <= '0;
    else if (latch_tuser) tuser_reg <= s_axis_tuser;
  end

endmodule

// File: tb/tb_my_downconverter.sv
`timescale 1ns/1ps
// Bench for my_downconverter: a driver pushes expected 64-bit beats into a
// scoreboard queue; an independent monitor pops and compares each accepted
// output beat, tracks len_err pulses and checks stability under stall.
module tb_my_downconverter;

  logic         clk = 1'b0;
  logic         axi_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         len_err;
  logic [15:0]  len_err_count;

  my_downconverter dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .len_err       (len_err),
    .len_err_count (len_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int          exp_pulses = 0;
  int          obs_pulses = 0;
  logic [15:0] exp_count = 16'd0;
  int          pkt_bytes = 0;
  int          acc_n = 0;
  int          acc_first = 0;
  int          acc_last = 0;
  logic        stalled = 1'b0;
  logic [200:0] snap;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Output-side ready generator.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every accepted beat against the scoreboard.
  always @(negedge clk) begin
    if (axi_reset) begin
      stalled = 1'b0;
    end else begin
      if (len_err) obs_pulses++;
      if (stalled && m_axis_tvalid)
        check("stall_hold", {m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser}, snap);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_axis_tstrb, m_axis_tdata}, 256'd0);
        end else begin
          got = exp_q.pop_front();
          check("out_data", m_axis_tdata, got.data);
          check("out_strb", m_axis_tstrb, got.strb);
          check("out_last", m_axis_tlast, got.last);
          check("out_user", m_axis_tuser, got.user);
        end
        if (acc_n == 0) acc_first = cyc;
        acc_last = cyc;
        acc_n++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      snap    = {m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser};
    end
  end

  // Reference model: expected lanes of one input beat plus length tracking.
  task automatic push_beat(input logic [255:0] d, input logic [31:0] s, input logic last,
                           input logic [127:0] u);
    int    nl;
    beat_t b;
    nl = 3;
    if (last) begin
      nl = 0;
      for (int k = 0; k < 4; k++) if (s[8*k +: 8] != 8'd0) nl = k;
    end
    for (int k = 0; k <= nl; k++) begin
      b.data = d[64*k +: 64];
      b.strb = s[8*k +: 8];
      b.last = last && (k == nl);
      b.user = u;
      exp_q.push_back(b);
      pkt_bytes += $countones(s[8*k +: 8]);
    end
    if (last) begin
      if (pkt_bytes != int'(u[15:0])) begin
        exp_pulses++;
        if (exp_count != 16'hFFFF) exp_count++;
      end
      pkt_bytes = 0;
    end
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("accept_timeout", t, 0);
    @(posedge clk);
    #1;
  endtask

  // Drives one beat (drive_u on the bus, pkt_u is the packet's first TUSER).
  task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic last,
                           input logic [127:0] drive_u, input logic [127:0] pkt_u);
    push_beat(d, s, last, pkt_u);
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tlast  = last;
    s_axis_tuser  = drive_u;
    s_axis_tvalid = 1'b1;
    wait_accept();
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_len(input string tag);
    check({tag, "_err_count"}, len_err_count, exp_count);
    check({tag, "_err_pulses"}, obs_pulses, exp_pulses);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [127:0] rand_user();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Global bound on run time.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got cycle %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d0, d1, d2;
    logic [127:0] u0, u1;
    beat_t        b;
    int           nb, nbytes, plen;
    logic [31:0]  ls;

    axi_reset     = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tstrb", m_axis_tstrb, 8'd0);
    check("rst_tuser", m_axis_tuser, 128'd0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_count", len_err_count, 16'd0);
    check("rst_sready", s_axis_tready, 1'b0);
    axi_reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_sready", s_axis_tready, 1'b1);

    // Single beat, 8 bytes, correct length.
    d0 = rand_data();
    u0 = rand_user();
    u0[15:0] = 16'd8;
    send_beat(d0, 32'h0000_00FF, 1'b1, u0, u0);
    idle();
    drain();
    check_len("single");

    // 60-byte packet in two beats; later beat drives a different TUSER.
    d0 = rand_data();
    d1 = rand_data();
    u0 = rand_user();
    u0[15:0] = 16'd60;
    u1 = rand_user();
    acc_n = 0;
    send_beat(d0, 32'hFFFF_FFFF, 1'b0, u0, u0);
    send_beat(d1, 32'h0FFF_FFFF, 1'b1, u1, u0);
    idle();
    drain();
    check("p60_beats", acc_n, 8);
    check("p60_contig", acc_last - acc_first, 7);
    check_len("p60");

    // Same packet with a wrong length: data unchanged, one error.
    u0[15:0] = 16'd64;
    send_beat(d0, 32'hFFFF_FFFF, 1'b0, u0, u0);
    send_beat(d1, 32'h0FFF_FFFF, 1'b1, u1, u0);
    idle();
    drain();
    check("p64_count_is_1", len_err_count, 16'd1);
    check_len("p64");

    // Final beat with all-zero strobes still emits lane 0 with tlast.
    u0 = rand_user();
    u0[15:0] = 16'd32;
    send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0, u0, u0);
    send_beat(rand_data(), 32'h0000_0000, 1'b1, u0, u0);
    idle();
    drain();
    check_len("zero_strb");

    // Random packets under random backpressure.
    rdy_mode = 1;
    for (int p = 0; p < 100; p++) begin
      nb     = $urandom_range(1, 4);
      nbytes = $urandom_range(1, 32);
      ls     = (nbytes == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbytes) - 32'h1);
      plen   = 32 * (nb - 1) + nbytes;
      u0     = rand_user();
      u0[15:0] = 16'(($urandom_range(0, 7) == 0) ? plen + 1 : plen);
      for (int i = 0; i < nb; i++) begin
        if (i == nb - 1) send_beat(rand_data(), ls, 1'b1, (i == 0) ? u0 : rand_user(), u0);
        else             send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0, (i == 0) ? u0 : rand_user(), u0);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    rdy_mode = 0;
    check_len("random");

    // Reset while lane 2 of the first beat of a 3-beat packet is on the bus.
    d0 = rand_data();
    u0 = rand_user();
    u0[15:0] = 16'd96;
    for (int k = 0; k < 2; k++) begin
      b.data = d0[64*k +: 64];
      b.strb = 8'hFF;
      b.last = 1'b0;
      b.user = u0;
      exp_q.push_back(b);
    end
    s_axis_tdata  = d0;
    s_axis_tstrb  = 32'hFFFF_FFFF;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = u0;
    s_axis_tvalid = 1'b1;
    wait_accept();
    idle();
    @(posedge clk);
    @(negedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #2;
    axi_reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_count", len_err_count, 16'd0);
    check("midrst_pending", exp_q.size(), 0);
    exp_count = 16'd0;
    pkt_bytes = 0;
    rdy_mode  = 0;
    repeat (2) @(posedge clk);
    #1;
    axi_reset = 1'b0;

    // Clean packet after reset.
    d0 = rand_data();
    d1 = rand_data();
    u0 = rand_user();
    u0[15:0] = 16'd60;
    send_beat(d0, 32'hFFFF_FFFF, 1'b0, u0, u0);
    send_beat(d1, 32'h0FFF_FFFF, 1'b1, rand_user(), u0);
    idle();
    drain();
    check_len("post_rst");

    // Saturate the error counter with one-byte packets claiming length 0.
    u0 = rand_user();
    u0[15:0] = 16'd0;
    while (exp_count != 16'hFFFF) send_beat(d0, 32'h0000_0001, 1'b1, u0, u0);
    idle();
    drain();
    check_len("sat_reach");
    send_beat(d1, 32'h0000_0001, 1'b1, u0, u0);
    idle();
    drain();
    check("sat_hold", len_err_count, 16'hFFFF);
    check_len("sat_more");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
